uart_8250: RTL and testbench
============================

Name: uart_8250

Overview:
- COM1 serial port at I/O 0x3F8–0x3FF, register-compatible with the 8250.
- Gives the CPU bus a byte-stream receive path, for example from a PS/2-to-Microsoft-serial-mouse packetizer, and a transmit byte stream.
- Raises IRQ4 toward the PIC.
- Its read data joins the cpu_data_in priority mux next to pic/pit/keyboard.

Parameters:
BASE, 16'h03F8, I/O base address (8 registers, iAddr[2:0] selects).
RX_DEPTH, 16, receive buffer depth in bytes (power of 2, >=2).

Ports:
iClk  input  1  bus clock
iRstN  input  1  reset, asynchronous, active-low
iAddr  input  20  CPU address; I/O decode uses iAddr[15:3]==BASE[15:3]
iWrData  input  8  CPU write data
iWr  input  1  CPU I/O write strobe (level, may span several cycles)
iRd  input  1  CPU I/O read strobe (level, may span several cycles)
oRdData  output  8  register read data
oSel  output  1  iRd & address hit (combinational)
iRxData  input  8  incoming serial byte
iRxValid  input  1  incoming byte valid
oRxReady  output  1  buffer not full; a byte is accepted when iRxValid & oRxReady
oTxData  output  8  outgoing byte
oTxValid  output  1  outgoing byte valid, held until accepted
iTxReady  input  1  consumer accepts when oTxValid & iTxReady
oIrq  output  1  IRQ4 request to PIC (level)
oDtr  output  1  MCR[0]
oRts  output  1  MCR[1]

Behaviour:
- Reset (iRstN low, asynchronous) sets:
  - RX buffer empty, so oRxReady=1.
  - oTxValid=0, oTxData=0.
  - IER=0, LCR=0, MCR=0, SCR=0, DLL=0x0C, DLM=0.
  - THRE-pending=0, oIrq=0, oDtr=0, oRts=0.
  - Edge-detect registers cleared.
  - Reset mid-transfer discards all buffered bytes and any pending TX byte.
- Strobes:
  - iWr and iRd are registered each cycle.
  - Write side effects occur once, on the cycle iWr is high and was low the previous cycle.
  - Read side effects (RBR pop, IIR ack) follow the same rule on iRd.
  - Holding a strobe for many cycles produces exactly one effect.
- Register map (offset, DLAB=LCR[7]):
  - 0 R, DLAB=0: RBR, the head of the RX buffer, or 0x00 if empty. The rising edge pops one entry if non-empty.
  - 0 W, DLAB=0: THR. Loads oTxData, sets oTxValid=1, clears THRE-pending.
  - 0 RW, DLAB=1: DLL (storage only, no baud timing).
  - 1 RW, DLAB=0: IER; only bits [3:0] are stored, bits [7:4] read 0.
  - 1 RW, DLAB=1: DLM.
  - 2 R: IIR, as defined under Interrupts below.
  - 3 RW: LCR.
  - 4 RW: MCR; only bits [4:0] are stored, bits [7:5] read 0. Loopback (MCR[4]) is stored but has no effect.
  - 5 R: LSR = {1'b0, TEMT, THRE, 4'b0, DR}.
    - DR = buffer non-empty.
    - THRE = TEMT = ~oTxValid.
    - OE is never set, because the handshake prevents overrun.
  - 5 W: ignored.
  - 6 R: MSR = 8'hB0 (CTS, DSR, DCD asserted; RI and delta bits 0).
  - 6 W: ignored.
  - 7 RW: SCR.
- RX buffer: circular, RX_DEPTH entries, with occupancy counter width clog2(RX_DEPTH)+1.
  - A push and a pop in the same cycle are both honoured; the count is unchanged and ordering is preserved.
  - Full: oRxReady=0 and the source stalls.
  - A pop when empty is a no-op.
  - Pointers wrap modulo RX_DEPTH.
- TX:
  - oTxValid clears in the cycle after iTxReady is sampled high.
  - The falling transition of oTxValid sets THRE-pending.
  - A THR write while oTxValid=1 overwrites oTxData, and valid remains 1.
  - If a THR write and acceptance happen in the same cycle, the write wins: valid stays 1 with the new data, and THRE-pending stays clear.
- Interrupts:
  - A write to IER that takes bit 1 from 0 to 1 while THRE=1 sets THRE-pending.
  - IIR priority:
    - 0x04 if IER[0] & DR;
    - else 0x02 if IER[1] & THRE-pending;
    - else 0x01.
  - Reading IIR when it returns 0x02 clears THRE-pending.
  - The RX interrupt clears only by emptying the buffer.
  - oIrq = (IIR[0]==0) & MCR[3] (OUT2 gating), registered, so it reflects state one cycle later.
- Read path: oRdData is combinational from registered state and decoded offset. It returns 0x00 when there is no hit.

Test Plan:
- Reset then read 0x3F9..0x3FF. Required: IER=00, IIR=01, LCR=00, MCR=00, LSR=60, MSR=B0, SCR=00; oIrq=0 and oRxReady=1.
- Set MCR=0x0B and IER=0x01, then push 0x4D. Required: within 2 cycles oIrq=1 and IIR=04. Reading RBR returns 4D, then LSR=60 and oIrq drops.
- Push 16 bytes 0x00..0x0F with iRxValid held high. Required: oRxReady=0 after the 16th, and a 17th byte is held. One read returns 00 and oRxReady goes to 1. The 17th byte is accepted, and the last read returns it in order.
- Hold iRd high for 10 cycles on RBR with 3 bytes buffered. Required: exactly one pop (LSR.DR still 1, next read returns the second byte).
- MCR=08, IER=02. Required: IIR=02 and oIrq=1. Reading IIR clears the interrupt (next IIR=01). Writing THR=0x55 gives oTxValid=1 and oTxData=55. With iTxReady=1, valid drops and IIR=02 again.
- LCR=0x80, write 0x3F8=0x01 and 0x3F9=0x00. Required: no oTxValid and IER unchanged. With LCR=0x03, DLL reads back 01 once DLAB is set again.
- Assert iRstN low mid-stream with 5 bytes buffered and oTxValid=1. Required: immediately oTxValid=0 and oIrq=0; after release LSR=60.

Source files
------------

// File: rtl/uart_8250.sv
// uart_8250: COM1-style, 8250 register-compatible serial port front end.
// The serial line itself is abstracted away: received bytes arrive on a
// valid/ready stream into a small circular buffer, and THR writes leave on
// a valid/ready stream. Divisor latches are stored only, with no baud timing.
//
// Ports:
//   iClk, iRstN          bus clock, asynchronous active-low reset
//   iAddr, iWrData       CPU address / write data
//   iWr, iRd             CPU I/O strobes (level; one effect per rising edge)
//   oRdData, oSel        register read data, read-select for the CPU data mux
//   iRxData, iRxValid    incoming byte stream
//   oRxReady             buffer not full
//   oTxData, oTxValid    outgoing byte stream (held until accepted)
//   iTxReady             consumer accept
//   oIrq                 IRQ4 level request, gated by MCR[3] (OUT2)
//   oDtr, oRts           MCR[0], MCR[1]
module uart_8250 #(
  parameter logic [15:0] BASE     = 16'h03F8,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [19:0] iAddr,
  input  logic [7:0]  iWrData,
  input  logic        iWr,
  input  logic        iRd,
  output logic [7:0]  oRdData,
  output logic        oSel,
  input  logic [7:0]  iRxData,
  input  logic        iRxValid,
  output logic        oRxReady,
  output logic [7:0]  oTxData,
  output logic        oTxValid,
  input  logic        iTxReady,
  output logic        oIrq,
  output logic        oDtr,
  output logic        oRts
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_IER  = 3'd1;
  localparam logic [2:0] OFF_IIR  = 3'd2;
  localparam logic [2:0] OFF_LCR  = 3'd3;
  localparam logic [2:0] OFF_MCR  = 3'd4;
  localparam logic [2:0] OFF_LSR  = 3'd5;
  localparam logic [2:0] OFF_MSR  = 3'd6;
  localparam logic [2:0] OFF_SCR  = 3'd7;

  localparam logic [7:0] IIR_RX   = 8'h04;
  localparam logic [7:0] IIR_THRE = 8'h02;
  localparam logic [7:0] IIR_NONE = 8'h01;

  // Strobe edge detect
  logic r_wr_q;
  logic r_rd_q;

  // Architectural registers
  logic [3:0] r_ier;
  logic [7:0] r_lcr;
  logic [4:0] r_mcr;
  logic [7:0] r_scr;
  logic [7:0] r_dll;
  logic [7:0] r_dlm;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_thre_pend;
  logic       r_irq;

  // RX circular buffer
  logic [7:0]    r_rx_mem [RX_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic       w_hit;
  logic [2:0] w_off;
  logic       w_dlab;
  logic       w_we;
  logic       w_re;
  logic       w_dr;
  logic       w_push;
  logic       w_pop;
  logic       w_thr_wr;
  logic       w_ier_wr;
  logic       w_tx_acc;
  logic       w_thre_arm;
  logic       w_iir_ack;
  logic       w_thre_pend_d;
  logic [7:0] w_iir;
  logic [7:0] w_rbr;
  logic [7:0] w_lsr;
  logic       w_unused_addr;

  assign w_unused_addr = ^iAddr[19:16];

  assign w_hit  = (iAddr[15:3] == BASE[15:3]);
  assign w_off  = iAddr[2:0];
  assign w_dlab = r_lcr[7];
  assign oSel   = iRd & w_hit;

  // One effect per strobe assertion, however long the CPU holds it
  assign w_we = iWr & ~r_wr_q & w_hit;
  assign w_re = iRd & ~r_rd_q & w_hit;

  assign w_dr     = (r_count != '0);
  assign oRxReady = (r_count != FULL_CNT);
  assign w_push   = iRxValid & oRxReady;
  assign w_pop    = w_re & (w_off == OFF_DATA) & ~w_dlab & w_dr;

  assign w_thr_wr = w_we & (w_off == OFF_DATA) & ~w_dlab;
  assign w_ier_wr = w_we & (w_off == OFF_IER) & ~w_dlab;
  assign w_tx_acc = r_tx_valid & iTxReady;

  // Enabling the THRE interrupt while the holding register is already empty
  // must raise it immediately, as on a real 8250.
  assign w_thre_arm = w_ier_wr & ~r_ier[1] & iWrData[1] & ~r_tx_valid;

  always_comb begin
    w_iir = IIR_NONE;
    if (r_ier[0] && w_dr) begin
      w_iir = IIR_RX;
    end else if (r_ier[1] && r_thre_pend) begin
      w_iir = IIR_THRE;
    end
  end

  assign w_iir_ack = w_re & (w_off == OFF_IIR) & (w_iir == IIR_THRE);

  // Later assignments take priority: a THR write always leaves pending clear.
  always_comb begin
    w_thre_pend_d = r_thre_pend;
    if (w_iir_ack) begin
      w_thre_pend_d = 1'b0;
    end
    if (w_tx_acc || w_thre_arm) begin
      w_thre_pend_d = 1'b1;
    end
    if (w_thr_wr) begin
      w_thre_pend_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_wr_q <= 1'b0;
      r_rd_q <= 1'b0;
    end else begin
      r_wr_q <= iWr;
      r_rd_q <= iRd;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_ier <= 4'h0;
      r_lcr <= 8'h00;
      r_mcr <= 5'h00;
      r_scr <= 8'h00;
      r_dll <= 8'h0C;
      r_dlm <= 8'h00;
    end else if (w_we) begin
      case (w_off)
        OFF_DATA: if (w_dlab) r_dll <= iWrData;
        OFF_IER: begin
          if (w_dlab) r_dlm <= iWrData;
          else        r_ier <= iWrData[3:0];
        end
        OFF_LCR: r_lcr <= iWrData;
        OFF_MCR: r_mcr <= iWrData[4:0];
        OFF_SCR: r_scr <= iWrData;
        default: ;
      endcase
    end
  end

  // A THR write in the same cycle as acceptance wins: the new byte stays valid.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_thre_pend <= 1'b0;
    end else begin
      r_thre_pend <= w_thre_pend_d;
      if (w_thr_wr) begin
        r_tx_data  <= iWrData;
        r_tx_valid <= 1'b1;
      end else if (w_tx_acc) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= ~w_iir[0] & r_mcr[3];
    end
  end

  // Buffer storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_rx_mem[r_wptr] <= iRxData;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign w_rbr = w_dr ? r_rx_mem[r_rptr] : 8'h00;
  assign w_lsr = {1'b0, ~r_tx_valid, ~r_tx_valid, 4'b0000, w_dr};

  always_comb begin
    oRdData = 8'h00;
    if (w_hit) begin
      case (w_off)
        OFF_DATA: oRdData = w_dlab ? r_dll : w_rbr;
        OFF_IER:  oRdData = w_dlab ? r_dlm : {4'h0, r_ier};
        OFF_IIR:  oRdData = w_iir;
        OFF_LCR:  oRdData = r_lcr;
        OFF_MCR:  oRdData = {3'b000, r_mcr};
        OFF_LSR:  oRdData = w_lsr;
        OFF_MSR:  oRdData = 8'hB0;
        OFF_SCR:  oRdData = r_scr;
        default:  oRdData = 8'h00;
      endcase
    end
  end

  assign oTxData  = r_tx_data;
  assign oTxValid = r_tx_valid;
  assign oIrq     = r_irq;
  assign oDtr     = r_mcr[0];
  assign oRts     = r_mcr[1];

endmodule

// File: tb/tb_uart_8250.sv
// tb_uart_8250: self-checking bench for uart_8250. A queue-based behavioural
// model of the register file tracks every CPU access, RX push and TX accept;
// directed sequences cover the boundary cases, then a randomized mix runs.
module tb_uart_8250;

  localparam logic [15:0] BASE  = 16'h03F8;
  localparam int unsigned DEPTH = 16;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic [19:0] iAddr = '0;
  logic [7:0]  iWrData = '0;
  logic        iWr = 1'b0;
  logic        iRd = 1'b0;
  logic [7:0]  oRdData;
  logic        oSel;
  logic [7:0]  iRxData = '0;
  logic        iRxValid = 1'b0;
  logic        oRxReady;
  logic [7:0]  oTxData;
  logic        oTxValid;
  logic        iTxReady = 1'b0;
  logic        oIrq;
  logic        oDtr;
  logic        oRts;

  uart_8250 #(.BASE(BASE), .RX_DEPTH(DEPTH)) u_dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iAddr    (iAddr),
    .iWrData  (iWrData),
    .iWr      (iWr),
    .iRd      (iRd),
    .oRdData  (oRdData),
    .oSel     (oSel),
    .iRxData  (iRxData),
    .iRxValid (iRxValid),
    .oRxReady (oRxReady),
    .oTxData  (oTxData),
    .oTxValid (oTxValid),
    .iTxReady (iTxReady),
    .oIrq     (oIrq),
    .oDtr     (oDtr),
    .oRts     (oRts)
  );

  always #5 iClk = ~iClk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [3:0] m_ier;
  logic [7:0] m_lcr;
  logic [4:0] m_mcr;
  logic [7:0] m_scr;
  logic [7:0] m_dll;
  logic [7:0] m_dlm;
  logic [7:0] m_txd;
  logic       m_txv;
  logic       m_pend;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ier = 4'h0; m_lcr = 8'h00; m_mcr = 5'h00; m_scr = 8'h00;
    m_dll = 8'h0C; m_dlm = 8'h00; m_txd = 8'h00; m_txv = 1'b0; m_pend = 1'b0;
  endtask

  function automatic logic [7:0] m_iir();
    if (m_ier[0] && m_q.size() != 0) return 8'h04;
    if (m_ier[1] && m_pend) return 8'h02;
    return 8'h01;
  endfunction

  function automatic logic m_irq();
    return (m_iir() != 8'h01) && m_mcr[3];
  endfunction

  task automatic m_read(input logic [2:0] off, output logic [7:0] v);
    logic dlab;
    dlab = m_lcr[7];
    case (off)
      3'd0: begin
        if (dlab) v = m_dll;
        else if (m_q.size() != 0) v = m_q.pop_front();
        else v = 8'h00;
      end
      3'd1: v = dlab ? m_dlm : {4'h0, m_ier};
      3'd2: begin
        v = m_iir();
        if (v == 8'h02) m_pend = 1'b0;
      end
      3'd3: v = m_lcr;
      3'd4: v = {3'b000, m_mcr};
      3'd5: v = {1'b0, !m_txv, !m_txv, 4'h0, m_q.size() != 0};
      3'd6: v = 8'hB0;
      default: v = m_scr;
    endcase
  endtask

  task automatic m_write(input logic [2:0] off, input logic [7:0] d);
    logic dlab;
    dlab = m_lcr[7];
    case (off)
      3'd0: begin
        if (dlab) m_dll = d;
        else begin m_txd = d; m_txv = 1'b1; m_pend = 1'b0; end
      end
      3'd1: begin
        if (dlab) m_dlm = d;
        else begin
          if (!m_ier[1] && d[1] && !m_txv) m_pend = 1'b1;
          m_ier = d[3:0];
        end
      end
      3'd3: m_lcr = d;
      3'd4: m_mcr = d[4:0];
      3'd7: m_scr = d;
      default: ;
    endcase
  endtask

  function automatic logic [19:0] addr_of(input logic [2:0] off);
    return {4'h0, BASE[15:3], off};
  endfunction

  task automatic check_outs(input string tag);
    check_eq({tag, "/irq"}, 32'(oIrq), 32'(m_irq()));
    check_eq({tag, "/txv"}, 32'(oTxValid), 32'(m_txv));
    if (m_txv) check_eq({tag, "/txd"}, 32'(oTxData), 32'(m_txd));
    check_eq({tag, "/rxrdy"}, 32'(oRxReady), 32'(m_q.size() < DEPTH));
    check_eq({tag, "/dtr_rts"}, 32'({oRts, oDtr}), 32'(m_mcr[1:0]));
  endtask

  // All bus tasks start just after a falling edge and end on one.
  task automatic bus_wr(input string tag, input logic [2:0] off, input logic [7:0] d);
    iAddr = addr_of(off); iWrData = d; iWr = 1'b1;
    m_write(off, d);
    @(negedge iClk);
    iWr = 1'b0;
    @(negedge iClk);
    check_outs(tag);
  endtask

  task automatic bus_rd_chk(input string tag, input logic [2:0] off);
    logic [7:0] obs, exp;
    iAddr = addr_of(off); iRd = 1'b1;
    #2;
    obs = oRdData;
    m_read(off, exp);
    check_eq(tag, 32'(obs), 32'(exp));
    @(negedge iClk);
    iRd = 1'b0;
    @(negedge iClk);
    check_outs(tag);
  endtask

  task automatic rx_push(input string tag, input logic [7:0] d);
    iRxData = d; iRxValid = 1'b1;
    #2;
    check_eq({tag, "/ready"}, 32'(oRxReady), 32'(m_q.size() < DEPTH));
    if (m_q.size() < DEPTH) m_q.push_back(d);
    @(negedge iClk);
    iRxValid = 1'b0;
    @(negedge iClk);
    check_outs(tag);
  endtask

  task automatic tx_accept(input string tag);
    iTxReady = 1'b1;
    @(negedge iClk);
    iTxReady = 1'b0;
    if (m_txv) begin m_txv = 1'b0; m_pend = 1'b1; end
    @(negedge iClk);
    check_outs(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] obs, exp;
    m_reset();
    repeat (3) @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);

    // Reset state
    check_eq("reset/txd", 32'(oTxData), 32'h00);
    check_outs("reset");
    for (int i = 1; i < 8; i++) bus_rd_chk("reset_reg", 3'(i));
    bus_wr("dlab_on", 3'd3, 8'h80);
    bus_rd_chk("reset_dll", 3'd0);
    bus_rd_chk("reset_dlm", 3'd1);
    bus_wr("dlab_off", 3'd3, 8'h00);

    // Address miss returns zero and no select
    iAddr = 20'h002F8; iRd = 1'b1;
    #2;
    check_eq("miss/data", 32'(oRdData), 32'h00);
    check_eq("miss/sel", 32'(oSel), 32'h0);
    iAddr = addr_of(3'd6);
    #1;
    check_eq("hit/sel", 32'(oSel), 32'h1);
    @(negedge iClk); iRd = 1'b0; @(negedge iClk);

    // RX interrupt path
    bus_wr("mcr0b", 3'd4, 8'h0B);
    bus_wr("ier01", 3'd1, 8'h01);
    rx_push("push4d", 8'h4D);
    bus_rd_chk("iir_rx", 3'd2);
    bus_rd_chk("rbr4d", 3'd0);
    bus_rd_chk("lsr_after", 3'd5);

    // Fill to full with valid held, 17th byte stalls
    for (int i = 0; i < DEPTH; i++) begin
      iRxData = 8'(i); iRxValid = 1'b1;
      #2;
      check_eq("fill/ready", 32'(oRxReady), 32'h1);
      m_q.push_back(8'(i));
      @(negedge iClk);
    end
    iRxData = 8'h10;
    #2;
    check_eq("full/ready", 32'(oRxReady), 32'h0);
    repeat (3) @(negedge iClk);
    check_eq("full/held", 32'(oRxReady), 32'h0);
    iAddr = addr_of(3'd0); iRd = 1'b1;
    #2;
    obs = oRdData;
    m_read(3'd0, exp);
    check_eq("full/rbr", 32'(obs), 32'(exp));
    @(negedge iClk);
    check_eq("full/ready_after_pop", 32'(oRxReady), 32'h1);
    iRd = 1'b0;
    m_q.push_back(8'h10);
    @(negedge iClk);
    iRxValid = 1'b0;
    @(negedge iClk);
    check_outs("full17");
    for (int i = 0; i < DEPTH; i++) bus_rd_chk("drain", 3'd0);

    // Long read strobe pops once
    for (int i = 0; i < 3; i++) rx_push("pre_hold", 8'($urandom_range(0, 255)));
    iAddr = addr_of(3'd0); iRd = 1'b1;
    #2;
    obs = oRdData;
    m_read(3'd0, exp);
    check_eq("hold/rbr", 32'(obs), 32'(exp));
    repeat (10) @(negedge iClk);
    iRd = 1'b0;
    @(negedge iClk);
    bus_rd_chk("hold/lsr", 3'd5);
    bus_rd_chk("hold/rbr2", 3'd0);
    bus_rd_chk("hold/rbr3", 3'd0);

    // THRE interrupt path
    bus_wr("mcr08", 3'd4, 8'h08);
    bus_wr("ier02", 3'd1, 8'h02);
    bus_rd_chk("iir_thre", 3'd2);
    bus_rd_chk("iir_acked", 3'd2);
    bus_wr("thr55", 3'd0, 8'h55);
    tx_accept("acc55");
    bus_rd_chk("iir_thre2", 3'd2);

    // THR write racing acceptance: write wins
    bus_wr("thr11", 3'd0, 8'h11);
    iAddr = addr_of(3'd0); iWrData = 8'h22; iWr = 1'b1; iTxReady = 1'b1;
    m_write(3'd0, 8'h22);
    @(negedge iClk);
    iWr = 1'b0; iTxReady = 1'b0;
    @(negedge iClk);
    check_outs("race");
    bus_rd_chk("race/iir", 3'd2);
    tx_accept("race_acc");

    // Divisor latch access does not touch THR or IER
    bus_wr("lcr80", 3'd3, 8'h80);
    bus_wr("dll01", 3'd0, 8'h01);
    bus_wr("dlm00", 3'd1, 8'h00);
    bus_wr("lcr03", 3'd3, 8'h03);
    bus_rd_chk("ier_kept", 3'd1);
    bus_wr("lcr83", 3'd3, 8'h83);
    bus_rd_chk("dll_rb", 3'd0);
    bus_wr("lcr03b", 3'd3, 8'h03);

    // Randomized mix
    for (int n = 0; n < 400; n++) begin
      logic [2:0] off;
      logic [7:0] d;
      off = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0, 1, 2: rx_push("rnd_push", d);
        3:       bus_rd_chk("rnd_rbr", 3'd0);
        4:       bus_rd_chk("rnd_rd", off);
        5:       bus_wr("rnd_wr", off, d);
        6:       tx_accept("rnd_acc");
        7:       bus_wr("rnd_ier", 3'd1, d);
        8:       bus_wr("rnd_thr", 3'd0, d);
        default: bus_rd_chk("rnd_iir", 3'd2);
      endcase
      if ((n % 50) == 49) bus_wr("rnd_lcr", 3'd3, 8'h03);
    end

    // Reset in the middle of traffic
    bus_wr("pre_rst_lcr", 3'd3, 8'h00);
    bus_wr("pre_rst_mcr", 3'd4, 8'h08);
    bus_wr("pre_rst_ier", 3'd1, 8'h01);
    while (m_q.size() != 0) bus_rd_chk("pre_rst_drain", 3'd0);
    for (int i = 0; i < 5; i++) rx_push("pre_rst_push", 8'(8'hA0 + i));
    bus_wr("pre_rst_thr", 3'd0, 8'hA5);
    iRstN = 1'b0;
    #1;
    check_eq("rst/txv", 32'(oTxValid), 32'h0);
    check_eq("rst/irq", 32'(oIrq), 32'h0);
    check_eq("rst/ready", 32'(oRxReady), 32'h1);
    m_reset();
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    bus_rd_chk("post_rst_lsr", 3'd5);
    bus_rd_chk("post_rst_rbr", 3'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
